sd_cmd_scheduler: RTL and testbench

SD_CMD_SCHEDULER -- requirements
Module: sd_cmd_scheduler

---
 rtl/sd_cmd_scheduler_if.sv | 53 +++++
 rtl/sd_cmd_scheduler.sv | 162 ++++++++++++++++
 tb/tb_sd_cmd_scheduler.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_scheduler_if.sv
// rtl/sd_cmd_scheduler_if.sv - request, command-master and status bundle of the SD command scheduler
interface sd_cmd_scheduler_if;
  // software command write
  logic        host_req_i;
  logic [15:0] host_set_i;
  logic [31:0] host_arg_i;
  // buffer-descriptor engine request/grant
  logic        bd_req_i;
  logic [15:0] bd_set_i;
  logic [31:0] bd_arg_i;
  logic        bd_gnt_o;
  // timeout and overrun control
  logic [15:0] time_out_i;
  logic        ovr_clr_i;
  // command master handshake
  logic        cmd_busy_i;
  logic        cmd_done_i;
  logic        cmd_err_i;
  logic        cmd_start_o;
  logic [15:0] cmd_set_o;
  logic [31:0] cmd_arg_o;
  // status
  logic        owner_o;
  logic        busy_o;
  logic        host_pend_o;
  logic        done_host_o;
  logic        done_bd_o;
  logic        err_o;
  logic        timeout_o;
  logic        overrun_o;

  // scheduler side
  modport slave (
    input  host_req_i, host_set_i, host_arg_i,
    input  bd_req_i, bd_set_i, bd_arg_i,
    input  time_out_i, ovr_clr_i,
    input  cmd_busy_i, cmd_done_i, cmd_err_i,
    output bd_gnt_o, cmd_start_o, cmd_set_o, cmd_arg_o,
    output owner_o, busy_o, host_pend_o,
    output done_host_o, done_bd_o, err_o, timeout_o, overrun_o
  );

  // requester / command-master side
  modport master (
    output host_req_i, host_set_i, host_arg_i,
    output bd_req_i, bd_set_i, bd_arg_i,
    output time_out_i, ovr_clr_i,
    output cmd_busy_i, cmd_done_i, cmd_err_i,
    input  bd_gnt_o, cmd_start_o, cmd_set_o, cmd_arg_o,
    input  owner_o, busy_o, host_pend_o,
    input  done_host_o, done_bd_o, err_o, timeout_o, overrun_o
  );
endinterface

// File: rtl/sd_cmd_scheduler.sv
// rtl/sd_cmd_scheduler.sv - arbitrates host and BD commands onto one command master with timeout
module sd_cmd_scheduler #(
  parameter int TO_PRESCALE = 8
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  sd_cmd_scheduler_if.slave bus
);

  localparam int PW = (TO_PRESCALE > 1) ? $clog2(TO_PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TO_PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_FINISH
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] host_set_q;
  logic [31:0] host_arg_q;
  logic        host_pend;
  logic        overrun;
  logic        last_owner;
  logic        owner;
  logic [15:0] cmd_set;
  logic [31:0] cmd_arg;
  logic [15:0] tick_cnt;
  logic [PW-1:0] presc_cnt;
  logic        to_en;
  logic        err_q;
  logic        to_q;

  logic        sel;
  logic        sel_bd;
  logic        host_clr;
  logic        expire;

  // Arbitration: pick a source in IDLE, alternating when both are asking
  always_comb begin
    sel      = 1'b0;
    sel_bd   = 1'b0;
    host_clr = 1'b0;
    expire   = 1'b0;
    sel      = (state == S_IDLE) && !bus.cmd_busy_i && (host_pend || bus.bd_req_i);
    // with both requesting, BD wins only if the host was served last
    sel_bd   = bus.bd_req_i && (!host_pend || !last_owner);
    host_clr = sel && !sel_bd;
    // the last tick runs out on the cycle whose prescaler wraps with one tick left
    expire   = to_en && (presc_cnt == '0) && (tick_cnt == 16'd1);
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (sel) state_nxt = S_START;
      S_START:  state_nxt = S_RUN;
      S_RUN:    if (bus.cmd_done_i || expire) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Host request holding slot; a second write before issue is dropped and flagged
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      host_set_q <= 16'd0;
      host_arg_q <= 32'd0;
      host_pend  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (bus.host_req_i && (!host_pend || host_clr)) begin
        host_set_q <= bus.host_set_i;
        host_arg_q <= bus.host_arg_i;
      end
      if (bus.host_req_i)  host_pend <= 1'b1;
      else if (host_clr)   host_pend <= 1'b0;
      // setting beats clearing on the same edge
      if (bus.host_req_i && host_pend && !host_clr) overrun <= 1'b1;
      else if (bus.ovr_clr_i)                       overrun <= 1'b0;
    end
  end

  // Issued command registers, held from selection until the next selection
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      owner   <= 1'b0;
      cmd_set <= 16'd0;
      cmd_arg <= 32'd0;
    end else if (sel) begin
      owner   <= sel_bd;
      cmd_set <= sel_bd ? bus.bd_set_i : host_set_q;
      cmd_arg <= sel_bd ? bus.bd_arg_i : host_arg_q;
    end
  end

  // Timeout: prescaler produces ticks, tick counter counts them down
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tick_cnt  <= 16'd0;
      presc_cnt <= '0;
      to_en     <= 1'b0;
    end else if (state == S_START) begin
      tick_cnt  <= bus.time_out_i;
      presc_cnt <= PRESC_MAX;
      to_en     <= (bus.time_out_i != 16'd0);
    end else if (state == S_RUN) begin
      if (presc_cnt == '0) begin
        presc_cnt <= PRESC_MAX;
        if (to_en) tick_cnt <= tick_cnt - 16'd1;
      end else begin
        presc_cnt <= presc_cnt - 1'b1;
      end
    end
  end

  // Completion status captured on leaving RUN; done beats a simultaneous expiry
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_q <= 1'b0;
      to_q  <= 1'b0;
    end else if (state == S_RUN) begin
      if (bus.cmd_done_i) begin
        err_q <= bus.cmd_err_i;
        to_q  <= 1'b0;
      end else if (expire) begin
        err_q <= 1'b0;
        to_q  <= 1'b1;
      end
    end
  end

  // Round-robin memory; host is favoured first after reset
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)               last_owner <= 1'b1;
    else if (state == S_FINISH) last_owner <= owner;
  end

  assign bus.cmd_start_o = (state == S_START);
  assign bus.bd_gnt_o    = (state == S_START) && owner;
  assign bus.busy_o      = (state != S_IDLE);
  assign bus.done_host_o = (state == S_FINISH) && !owner;
  assign bus.done_bd_o   = (state == S_FINISH) && owner;
  assign bus.err_o       = (state == S_FINISH) && err_q;
  assign bus.timeout_o   = (state == S_FINISH) && to_q;
  assign bus.cmd_set_o   = cmd_set;
  assign bus.cmd_arg_o   = cmd_arg;
  assign bus.owner_o     = owner;
  assign bus.host_pend_o = host_pend;
  assign bus.overrun_o   = overrun;

endmodule

// File: tb/tb_sd_cmd_scheduler.sv
// tb/tb_sd_cmd_scheduler.sv - self-checking bench for sd_cmd_scheduler
module tb_sd_cmd_scheduler;
  localparam int PRESC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sd_cmd_scheduler_if bus ();
  sd_cmd_scheduler #(.TO_PRESCALE(PRESC)) dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus));

  typedef struct {
    logic        src;       // 0 host, 1 BD
    logic [15:0] set;
    logic [31:0] arg;
    logic [15:0] tmo;
    int          done_at;   // RUN cycle (1-based) carrying cmd_done_i, 0 = never
    logic        err;
    logic [3:0]  exp_pulse; // {done_host, done_bd, err, timeout}
    int          exp_len;   // cycles from START to FINISH
  } vec_t;

  vec_t vecs[8];

  // reference model state
  bit          m_busy, m_owner, m_last, m_pend, m_ovr, m_err, m_to;
  int          m_age, m_end, m_dl;
  logic [15:0] m_set, m_hset;
  logic [31:0] m_arg, m_harg;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.host_req_i = 0; bus.host_set_i = 0; bus.host_arg_i = 0;
    bus.bd_req_i = 0;   bus.bd_set_i = 0;   bus.bd_arg_i = 0;
    bus.time_out_i = 0; bus.ovr_clr_i = 0;
    bus.cmd_busy_i = 0; bus.cmd_done_i = 0; bus.cmd_err_i = 0;
  endtask

  task automatic host_pulse(input logic [15:0] s, input logic [31:0] a);
    bus.host_req_i = 1; bus.host_set_i = s; bus.host_arg_i = a;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    do begin
      step();
      bus.host_req_i = 0;
      n++;
    end while (!bus.cmd_start_o && n < 40);
  endtask

  // one-cycle done in the first RUN cycle, then expect the owner's done pulse
  task automatic complete(input logic exp_owner, input string nm);
    step();
    bus.cmd_done_i = 1; bus.cmd_err_i = 0;
    step();
    bus.cmd_done_i = 0;
    check(nm, {bus.done_host_o, bus.done_bd_o}, exp_owner ? 2'b01 : 2'b10);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, k, len;
    step();
    bus.time_out_i = v.tmo;
    if (v.src) begin
      bus.bd_req_i = 1; bus.bd_set_i = v.set; bus.bd_arg_i = v.arg;
    end else begin
      host_pulse(v.set, v.arg);
    end
    lat = 0;
    do begin
      step();
      bus.host_req_i = 0;
      lat++;
    end while (!bus.cmd_start_o && lat < 20);
    check($sformatf("v%0d latency", idx), lat, v.src ? 1 : 2);
    check($sformatf("v%0d issue", idx),
          {bus.cmd_start_o, bus.bd_gnt_o, bus.owner_o, bus.cmd_set_o, bus.cmd_arg_o},
          {1'b1, v.src, v.src, v.set, v.arg});
    bus.bd_req_i = 0;
    k = 0; len = 0;
    while (len == 0 && k < 200) begin
      step();
      k++;
      bus.cmd_done_i = (k == v.done_at);
      bus.cmd_err_i  = v.err;
      if (bus.done_host_o || bus.done_bd_o) begin
        len = k;
        check($sformatf("v%0d pulses", idx),
              {bus.done_host_o, bus.done_bd_o, bus.err_o, bus.timeout_o}, v.exp_pulse);
      end
    end
    check($sformatf("v%0d length", idx), len, v.exp_len);
    step();
    bus.cmd_done_i = 0; bus.cmd_err_i = 0;
    check($sformatf("v%0d idle after", idx),
          {bus.busy_o, bus.cmd_start_o, bus.done_host_o, bus.done_bd_o, bus.err_o, bus.timeout_o}, 0);
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 1; m_pend = 0; m_ovr = 0; m_err = 0; m_to = 0;
    m_age = 0; m_end = -1; m_dl = 0;
    m_set = 0; m_hset = 0; m_arg = 0; m_harg = 0;
  endtask

  // Transaction-level rules: a command lives from START (age 0) to FINISH (age m_end);
  // FINISH comes one cycle after done, or after time_out*PRESC RUN cycles.
  task automatic model_step();
    bit is_start, is_fin, sel, pick_bd, host_clr;
    is_start = m_busy && m_age == 0;
    is_fin   = m_busy && m_age == m_end;
    sel      = !m_busy && !bus.cmd_busy_i && (m_pend || bus.bd_req_i);
    if (m_pend && bus.bd_req_i) pick_bd = !m_last;
    else                        pick_bd = bus.bd_req_i;
    host_clr = sel && !pick_bd;
    if (sel) begin
      m_busy = 1; m_age = 0; m_end = -1; m_owner = pick_bd;
      m_set = pick_bd ? bus.bd_set_i : m_hset;
      m_arg = pick_bd ? bus.bd_arg_i : m_harg;
    end else if (is_fin) begin
      m_busy = 0; m_last = m_owner;
    end else if (m_busy) begin
      if (is_start) m_dl = (bus.time_out_i != 0) ? int'(bus.time_out_i) * PRESC + 1 : 0;
      else if (bus.cmd_done_i) begin m_end = m_age + 1; m_err = bus.cmd_err_i; m_to = 0; end
      else if (m_dl != 0 && m_age + 1 == m_dl) begin m_end = m_age + 1; m_to = 1; m_err = 0; end
      m_age++;
    end
    if (bus.ovr_clr_i) m_ovr = 0;
    if (bus.host_req_i) begin
      if (m_pend && !host_clr) m_ovr = 1;
      else begin m_hset = bus.host_set_i; m_harg = bus.host_arg_i; end
      m_pend = 1;
    end else if (host_clr) begin
      m_pend = 0;
    end
  endtask

  task automatic model_compare(input int c);
    bit p_start, p_fin;
    p_start = m_busy && m_age == 0;
    p_fin   = m_busy && m_age == m_end;
    check($sformatf("model cycle %0d", c),
          {bus.cmd_start_o, bus.bd_gnt_o, bus.busy_o, bus.done_host_o, bus.done_bd_o,
           bus.err_o, bus.timeout_o, bus.owner_o, bus.host_pend_o, bus.overrun_o,
           bus.cmd_set_o, bus.cmd_arg_o},
          {p_start, p_start && m_owner, m_busy, p_fin && !m_owner, p_fin && m_owner,
           p_fin && m_err, p_fin && m_to, m_owner, m_pend, m_ovr, m_set, m_arg});
  endtask

  task automatic drive_random();
    bus.host_req_i = ($urandom % 6) == 0;
    bus.host_set_i = 16'($urandom);
    bus.host_arg_i = $urandom;
    if (bus.bd_req_i && bus.bd_gnt_o) bus.bd_req_i = 0;
    else if (!bus.bd_req_i && ($urandom % 5) == 0) begin
      bus.bd_req_i = 1; bus.bd_set_i = 16'($urandom); bus.bd_arg_i = $urandom;
    end
    bus.cmd_busy_i = ($urandom % 8) == 0;
    bus.cmd_done_i = ($urandom % 10) == 0;
    bus.cmd_err_i  = 1'($urandom);
    bus.ovr_clr_i  = ($urandom % 12) == 0;
    bus.time_out_i = 16'($urandom % 3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    vecs[0] = '{1'b0, 16'h0102, 32'hDEADBEEF, 16'd0,  3, 1'b0, 4'b1000,  4};
    vecs[1] = '{1'b1, 16'h1234, 32'h0BADF00D, 16'd0,  1, 1'b1, 4'b0110,  2};
    vecs[2] = '{1'b0, 16'hA5A5, 32'h12345678, 16'd3,  0, 1'b0, 4'b1001, 25};
    vecs[3] = '{1'b1, 16'h5A5A, 32'h87654321, 16'd3,  0, 1'b0, 4'b0101, 25};
    vecs[4] = '{1'b0, 16'h0F0F, 32'h00000001, 16'd1,  8, 1'b0, 4'b1000,  9};
    vecs[5] = '{1'b1, 16'hF0F0, 32'hFFFFFFFF, 16'd2, 15, 1'b1, 4'b0110, 16};
    vecs[6] = '{1'b0, 16'h7777, 32'hCAFEF00D, 16'd1,  9, 1'b1, 4'b1001,  9};
    vecs[7] = '{1'b1, 16'h0001, 32'h00000000, 16'd0, 40, 1'b0, 4'b0100, 41};

    clear_inputs();
    rst = 1;
    step(); step();
    check("reset outputs",
          {bus.cmd_start_o, bus.bd_gnt_o, bus.cmd_set_o, bus.cmd_arg_o, bus.owner_o, bus.busy_o,
           bus.host_pend_o, bus.done_host_o, bus.done_bd_o, bus.err_o, bus.timeout_o, bus.overrun_o}, 0);
    rst = 0;

    // contention right after reset: host first, then BD, then host again
    bus.cmd_busy_i = 1;
    host_pulse(16'h1111, 32'h11111111);
    bus.bd_req_i = 1; bus.bd_set_i = 16'h2222; bus.bd_arg_i = 32'h22222222;
    step(); bus.host_req_i = 0; step(); step();
    check("busy holds off", {bus.cmd_start_o, bus.busy_o, bus.host_pend_o}, 3'b001);
    bus.cmd_busy_i = 0;
    wait_start();
    check("rr 1 host", {bus.cmd_start_o, bus.owner_o, bus.bd_gnt_o, bus.cmd_set_o}, {3'b100, 16'h1111});
    complete(1'b0, "rr 1 done");
    wait_start();
    check("rr 2 bd", {bus.cmd_start_o, bus.owner_o, bus.bd_gnt_o, bus.cmd_set_o}, {3'b111, 16'h2222});
    bus.bd_req_i = 0;
    complete(1'b1, "rr 2 done");
    bus.cmd_busy_i = 1;
    host_pulse(16'h3333, 32'h33333333);
    bus.bd_req_i = 1; bus.bd_set_i = 16'h4444; bus.bd_arg_i = 32'h44444444;
    step(); bus.host_req_i = 0; step();
    bus.cmd_busy_i = 0;
    wait_start();
    check("rr 3 host", {bus.cmd_start_o, bus.owner_o, bus.cmd_set_o}, {2'b10, 16'h3333});
    complete(1'b0, "rr 3 done");
    wait_start();
    check("rr 4 bd", {bus.cmd_start_o, bus.owner_o, bus.cmd_set_o}, {2'b11, 16'h4444});
    bus.bd_req_i = 0;
    complete(1'b1, "rr 4 done");

    // overrun: two writes during RUN, the first is kept
    host_pulse(16'h5555, 32'h55555555);
    wait_start();
    step();
    host_pulse(16'h6666, 32'h66666666);
    step();
    host_pulse(16'h7777, 32'h77777777);
    bus.ovr_clr_i = 1;
    step();
    bus.host_req_i = 0; bus.ovr_clr_i = 0;
    check("overrun set wins", {bus.overrun_o, bus.host_pend_o, bus.busy_o}, 3'b111);
    bus.ovr_clr_i = 1;
    step();
    bus.ovr_clr_i = 0;
    check("overrun cleared", {bus.overrun_o, bus.host_pend_o}, 2'b01);
    complete(1'b0, "overrun cmd done");
    wait_start();
    check("overrun keeps first", {bus.cmd_start_o, bus.owner_o, bus.cmd_set_o, bus.cmd_arg_o},
          {2'b10, 16'h6666, 32'h66666666});
    complete(1'b0, "overrun second done");

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // asynchronous reset during RUN with a host request pending
    host_pulse(16'h8888, 32'h88888888);
    wait_start();
    step();
    host_pulse(16'h9999, 32'h99999999);
    step();
    bus.host_req_i = 0;
    check("pre reset", {bus.busy_o, bus.host_pend_o}, 2'b11);
    #2 rst = 1;
    #1;
    check("async reset", {bus.busy_o, bus.host_pend_o, bus.cmd_start_o, bus.done_host_o, bus.done_bd_o}, 0);
    step();
    rst = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen = seen | bus.busy_o | bus.cmd_start_o | bus.done_host_o | bus.done_bd_o | bus.host_pend_o;
    end
    check("no activity after reset", seen, 0);

    // randomized traffic against the transaction model
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      drive_random();
      @(posedge clk);
      model_step();
      #1;
      model_compare(c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
